// File: rtl/tmds_pkg.sv
// tmds_pkg: shared definitions for the TMDS video timing slice.
//   - state_t       : timing controller sequencer states
//   - *_640 consts  : default 640x480@60 timing (pixel clocks / lines)
//   - CTRL_CODE_*   : 10-bit TMDS control-period symbols, indexed by {c1, c0}
//   - ctrl_code()   : selects the control symbol for a given {c1, c0}
package tmds_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  localparam int H_ACTIVE_640 = 640;
  localparam int H_FP_640     = 16;
  localparam int H_SYNC_640   = 96;
  localparam int H_BP_640     = 48;
  localparam int V_ACTIVE_480 = 480;
  localparam int V_FP_480     = 10;
  localparam int V_SYNC_480   = 2;
  localparam int V_BP_480     = 33;

  localparam logic [9:0] CTRL_CODE_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_CODE_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_CODE_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_CODE_11 = 10'b1010101011;

  function automatic logic [9:0] ctrl_code(input logic c1, input logic c0);
    logic [9:0] code;
    case ({c1, c0})
      2'b00:   code = CTRL_CODE_00;
      2'b01:   code = CTRL_CODE_01;
      2'b10:   code = CTRL_CODE_10;
      default: code = CTRL_CODE_11;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/tmds_timing_ctrl_if.sv
// tmds_timing_ctrl_if: bundle between the timing controller and its consumers.
//   en          : run request, level-sensitive, sampled every clock
//   pix_req     : a pixel is needed next cycle; pix_x/pix_y name it
//   de, c0, c1  : data-enable, hsync, vsync to the three encoders
//   frame_start : one-cycle pulse with the first (h=0, v=0) output cycle
//   busy        : sequencer is in RUN or STOPPING
//   state       : sequencer state, for observation only
// Handshake: there is no ready. pix_req is a one-way request; the frame
// source must present the named pixel on the very next cycle, when de is
// high. en is a level: the controller starts on the next frame boundary
// after it rises and stops on the frame boundary after it falls.
interface tmds_timing_ctrl_if #(
  parameter int XW = 12,
  parameter int YW = 12
);
  import tmds_pkg::*;

  logic          en;
  logic          pix_req;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          de;
  logic          c0;
  logic          c1;
  logic          frame_start;
  logic          busy;
  state_t        state;

  modport master (
    input  en,
    output pix_req, pix_x, pix_y, de, c0, c1, frame_start, busy, state
  );

  modport slave (
    output en,
    input  pix_req, pix_x, pix_y, de, c0, c1, frame_start, busy, state
  );

endinterface

// File: rtl/tmds_axis_counter.sv
// tmds_axis_counter: one axis (horizontal or vertical) of the raster.
// Counts 0..TOTAL-1 where TOTAL = ACTIVE+FP+SYNC+BP, regions in that order.
//   clk, rst   : clock, asynchronous active-high reset (count -> 0)
//   clr        : hold the count at 0 (wins over step)
//   step       : advance by one, wrapping to 0 after TOTAL-1
//   cnt, nxt   : current count and the value it takes at the next edge
//   wrap       : current count is TOTAL-1
//   active     : current count is inside the active region
//   sync_win   : current count is inside the sync region (empty if SYNC=0)
//   nxt_active : next count is inside the active region
module tmds_axis_counter #(
  parameter int W      = 12,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         step,
  output logic [W-1:0] cnt,
  output logic [W-1:0] nxt,
  output logic         wrap,
  output logic         active,
  output logic         sync_win,
  output logic         nxt_active
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

  assign wrap       = (cnt == LAST);
  assign active     = (cnt < ACT_END);
  assign sync_win   = (cnt >= SYNC_START) && (cnt < SYNC_END);
  assign nxt_active = (nxt < ACT_END);

  always_comb begin
    nxt = cnt;
    if (clr) begin
      nxt = '0;
    end else if (step) begin
      nxt = wrap ? '0 : cnt + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= nxt;
    end
  end

endmodule

// File: rtl/tmds_timing_ctrl.sv
// tmds_timing_ctrl: raster timing generator that sequences the TMDS encoders.
//   clk, rst : pixel clock, asynchronous active-high reset
//   bus      : tmds_timing_ctrl_if.master (en in; pix_req/pix_x/pix_y, de,
//              c0 = hsync, c1 = vsync, frame_start, busy, state out)
// All outputs are registered. de/c0/c1/frame_start decode the counters of the
// current cycle, so they lag the counters by one clock. pix_req/pix_x/pix_y
// decode the counters' next values, so pix_req leads de by exactly one clock.
// Runs start and stop only on frame boundaries.
module tmds_timing_ctrl
  import tmds_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_640,
  parameter int H_FP     = H_FP_640,
  parameter int H_SYNC   = H_SYNC_640,
  parameter int H_BP     = H_BP_640,
  parameter int V_ACTIVE = V_ACTIVE_480,
  parameter int V_FP     = V_FP_480,
  parameter int V_SYNC   = V_SYNC_480,
  parameter int V_BP     = V_BP_480,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int XW       = 12,
  parameter int YW       = 12
) (
  input logic                clk,
  input logic                rst,
  tmds_timing_ctrl_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  geometry_fits: assert property (@(posedge clk)
    (H_TOTAL < (1 << XW)) && (V_TOTAL < (1 << YW)));

  state_t state, state_nxt;

  logic [XW-1:0] h_cnt, h_nxt;
  logic [YW-1:0] v_cnt, v_nxt;
  logic h_wrap, h_active, h_sync, h_nxt_active;
  logic v_wrap, v_active, v_sync, v_nxt_active;
  logic running, running_nxt;

  logic          pix_req_q, de_q, c0_q, c1_q, frame_start_q, busy_q;
  logic [XW-1:0] pix_x_q;
  logic [YW-1:0] pix_y_q;

  assign running     = (state != ST_IDLE);
  assign running_nxt = (state_nxt != ST_IDLE);

  // Counters are cleared for as long as we sit in IDLE, so the first cycle
  // after leaving IDLE is always h=0, v=0.
  tmds_axis_counter #(
    .W(XW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk(clk), .rst(rst), .clr(~running), .step(1'b1),
    .cnt(h_cnt), .nxt(h_nxt), .wrap(h_wrap), .active(h_active),
    .sync_win(h_sync), .nxt_active(h_nxt_active)
  );

  tmds_axis_counter #(
    .W(YW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk(clk), .rst(rst), .clr(~running), .step(h_wrap),
    .cnt(v_cnt), .nxt(v_nxt), .wrap(v_wrap), .active(v_active),
    .sync_win(v_sync), .nxt_active(v_nxt_active)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // STOPPING keeps the frame going; only the wrap of the last line returns
  // to IDLE, and a re-asserted en cancels the stop without touching counters.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:     if (bus.en) state_nxt = ST_RUN;
      ST_RUN:      if (!bus.en) state_nxt = ST_STOPPING;
      ST_STOPPING: begin
        if (bus.en) begin
          state_nxt = ST_RUN;
        end else if (h_wrap && v_wrap) begin
          state_nxt = ST_IDLE;
        end
      end
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_req_q     <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      de_q          <= 1'b0;
      c0_q          <= ~HS_POL;
      c1_q          <= ~VS_POL;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      de_q          <= running && h_active && v_active;
      c0_q          <= (running && h_sync) ? HS_POL : ~HS_POL;
      c1_q          <= (running && v_sync) ? VS_POL : ~VS_POL;
      frame_start_q <= running && (h_cnt == '0) && (v_cnt == '0);
      busy_q        <= running_nxt;
      // Lookahead: decode the counter values being loaded at this edge.
      pix_req_q     <= running_nxt && h_nxt_active && v_nxt_active;
      if (running_nxt && h_nxt_active && v_nxt_active) begin
        pix_x_q <= h_nxt;
        pix_y_q <= v_nxt;
      end
    end
  end

  assign bus.pix_req     = pix_req_q;
  assign bus.pix_x       = pix_x_q;
  assign bus.pix_y       = pix_y_q;
  assign bus.de          = de_q;
  assign bus.c0          = c0_q;
  assign bus.c1          = c1_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = busy_q;
  assign bus.state       = state;

endmodule

// File: tb/tb_tmds_timing_ctrl.sv
// tb_tmds_timing_ctrl: bench for tmds_timing_ctrl on an 8x6 raster
// (H 4/1/2/1, V 3/1/1/1, active-low syncs).
module tb_tmds_timing_ctrl;
  import tmds_pkg::*;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tmds_timing_ctrl_if #(.XW(12), .YW(12)) bus ();

  tmds_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .XW(12), .YW(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit model_chk = 1'b0;
  logic [23:0] exp_q[$];
  int fs_times[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // A run is a sequence of whole frames; the position within the frame is a
  // single index pos = v*HT + h. A run ends at a frame's last clock only if
  // en was low on that clock and on the one before it.
  bit m_run;
  int m_pos;
  bit m_en_prev;
  bit e_de, e_c0, e_c1, e_fs, e_busy, e_req;
  int e_x, e_y;

  function automatic bit in_win(input int p, input int lo, input int len);
    return (p >= lo) && (p < lo + len);
  endfunction

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_en_prev = 0;
    e_de = 0; e_c0 = 1; e_c1 = 1; e_fs = 0; e_busy = 0; e_req = 0;
    e_x = 0; e_y = 0;
  endtask

  task automatic model_edge(input bit en_v);
    int h, v;
    h = m_pos % HT;
    v = m_pos / HT;
    e_de = m_run && (h < HA) && (v < VA);
    e_c0 = !(m_run && in_win(h, HA + HF, HS));
    e_c1 = !(m_run && in_win(v, VA + VF, VS));
    e_fs = m_run && (m_pos == 0);
    if (!m_run) begin
      if (en_v) begin
        m_run = 1;
        m_pos = 0;
      end
    end else if ((m_pos == FT - 1) && !m_en_prev && !en_v) begin
      m_run = 0;
      m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % FT;
    end
    m_en_prev = en_v;
    h = m_pos % HT;
    v = m_pos / HT;
    e_busy = m_run;
    e_req  = m_run && (h < HA) && (v < VA);
    if (e_req) begin
      e_x = h;
      e_y = v;
    end
  endtask

  task automatic check_model();
    logic [23:0] exp_xy;
    chk("de", bus.de, e_de);
    chk("c0", bus.c0, e_c0);
    chk("c1", bus.c1, e_c1);
    chk("frame_start", bus.frame_start, e_fs);
    chk("busy", bus.busy, e_busy);
    chk("pix_req", bus.pix_req, e_req);
    chk("pix_x", bus.pix_x, e_x);
    chk("pix_y", bus.pix_y, e_y);
    if (e_req) exp_q.push_back({12'(e_y), 12'(e_x)});
    if (bus.pix_req) begin
      if (exp_q.size() == 0) begin
        chk("pix_unexpected", 1, 0);
      end else begin
        exp_xy = exp_q.pop_front();
        chk("pix_sb", {bus.pix_y, bus.pix_x}, exp_xy);
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called from a point away from the clock edge; drives en, waits one
  // rising edge and samples 1 time unit later.
  task automatic cycle(input bit en_v);
    bus.en = en_v;
    @(posedge clk);
    #1;
    cyc++;
    model_edge(en_v);
    if (bus.frame_start) fs_times.push_back(cyc);
    if (model_chk) check_model();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit en;
    bit req;
    int x;
    int y;
    bit de;
    bit fs;
    bit c0;
    bit busy;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input bit en, input bit req, input int x, input int y,
                              input bit de, input bit fs, input bit c0, input bit busy);
    vec_t r;
    r.en = en; r.req = req; r.x = x; r.y = y;
    r.de = de; r.fs = fs; r.c0 = c0; r.busy = busy;
    return r;
  endfunction

  // ---------------- test ----------------
  initial begin
    bit en_r;
    int c0_cyc;
    int guard;

    bus.en = 1'b0;
    model_reset();

    //            en req x  y  de fs c0 busy
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 1, 0);
    vecs[1]  = mk(1, 1, 0, 0, 0, 0, 1, 1);
    vecs[2]  = mk(1, 1, 1, 0, 1, 1, 1, 1);
    vecs[3]  = mk(1, 1, 2, 0, 1, 0, 1, 1);
    vecs[4]  = mk(1, 1, 3, 0, 1, 0, 1, 1);
    vecs[5]  = mk(1, 0, 3, 0, 1, 0, 1, 1);
    vecs[6]  = mk(1, 0, 3, 0, 0, 0, 1, 1);
    vecs[7]  = mk(1, 0, 3, 0, 0, 0, 0, 1);
    vecs[8]  = mk(1, 0, 3, 0, 0, 0, 0, 1);
    vecs[9]  = mk(1, 1, 0, 1, 0, 0, 1, 1);
    vecs[10] = mk(1, 1, 1, 1, 1, 0, 1, 1);
    vecs[11] = mk(1, 1, 2, 1, 1, 0, 1, 1);
    vecs[12] = mk(1, 1, 3, 1, 1, 0, 1, 1);

    // reset values while rst is held
    #12;
    chk("rst_de", bus.de, 0);
    chk("rst_c0", bus.c0, 1);
    chk("rst_c1", bus.c1, 1);
    chk("rst_fs", bus.frame_start, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_req", bus.pix_req, 0);
    chk("rst_x", bus.pix_x, 0);
    chk("rst_y", bus.pix_y, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // start-up sequence from the table
    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].en);
      chk($sformatf("tbl%0d_req", i), bus.pix_req, vecs[i].req);
      chk($sformatf("tbl%0d_x", i), bus.pix_x, vecs[i].x);
      chk($sformatf("tbl%0d_y", i), bus.pix_y, vecs[i].y);
      chk($sformatf("tbl%0d_de", i), bus.de, vecs[i].de);
      chk($sformatf("tbl%0d_fs", i), bus.frame_start, vecs[i].fs);
      chk($sformatf("tbl%0d_c0", i), bus.c0, vecs[i].c0);
      chk($sformatf("tbl%0d_c1", i), bus.c1, 1);
      chk($sformatf("tbl%0d_busy", i), bus.busy, vecs[i].busy);
    end

    // free-running frames: sync placement and frame period
    model_chk = 1'b1;
    repeat (60) cycle(1);
    for (int i = 1; i < fs_times.size(); i++)
      chk("fs_period", fs_times[i] - fs_times[i-1], FT);

    // stop on a frame boundary: drop en at line 1
    guard = 0;
    while (!(m_run && m_pos == HT) && guard < 100) begin
      cycle(1);
      guard++;
    end
    chk("wait_line1_timeout", guard < 100, 1);
    fs_times.delete();
    repeat (70) cycle(0);
    chk("stop_no_fs", fs_times.size(), 0);
    chk("stop_busy", bus.busy, 0);
    chk("stop_state", bus.state, ST_IDLE);

    // asynchronous reset mid-frame at line 1, h=2
    guard = 0;
    while (!(m_run && m_pos == HT + 2) && guard < 100) begin
      cycle(1);
      guard++;
    end
    chk("wait_rst_pt_timeout", guard < 100, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_de", bus.de, 0);
    chk("mid_rst_c0", bus.c0, 1);
    chk("mid_rst_c1", bus.c1, 1);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_req", bus.pix_req, 0);
    chk("mid_rst_state", bus.state, ST_IDLE);
    model_reset();
    exp_q.delete();
    #1;
    rst = 1'b0;
    fs_times.delete();
    c0_cyc = cyc;
    repeat (60) cycle(1);
    if (fs_times.size() == 0) chk("restart_fs_seen", 0, 1);
    else chk("restart_fs_delay", fs_times[0] - c0_cyc, 2);

    // en re-asserted on the final clock of a stopping frame
    guard = 0;
    while (m_pos != 0 && guard < 100) begin
      cycle(1);
      guard++;
    end
    chk("wait_frame0_timeout", guard < 100, 1);
    fs_times.delete();
    cycle(1);
    repeat (20) cycle(1);
    guard = 0;
    while (m_pos != FT - 1 && guard < 100) begin
      cycle(0);
      guard++;
    end
    chk("wait_last_timeout", guard < 100, 1);
    cycle(1);
    repeat (4) cycle(1);
    chk("rearm_fs_count", fs_times.size(), 2);
    if (fs_times.size() >= 2) chk("rearm_fs_period", fs_times[1] - fs_times[0], FT);

    // randomized en with long holds
    en_r = 1'b1;
    repeat (1000) begin
      if ($urandom_range(0, 24) == 0) en_r = ~en_r;
      cycle(en_r);
    end
    chk("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
